// File: rtl/fetch_unit.sv
// Generic FIFO: power-of-two ring buffer with a synchronous clear that discards all entries.
// Latency: one cycle from a write to the entry appearing on rd_dat; the read data is combinational from the head.
// Backpressure: full is asserted at DEPTH entries. A write while full is dropped unless a read happens in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (cnt != '0);
    assign full   = (cnt == CW'(DEPTH));
    assign rd_dat = mem[rd_ptr];
    assign do_rd  = rd_rdy && rd_vld;
    assign do_wr  = wr_vld && (!full || do_rd);

    // Pointers and occupancy; the pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; no reset is needed because the contents are only visible when the count is non-zero
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end
endmodule

// Fetch unit: issues SS-wide instruction-memory requests with one outstanding, and buffers the returned groups for decode.
// Latency: the request is issued from IDLE, the response comes back in WAIT, and the group reaches out_valid on the cycle after the response.
// Backpressure: out_ready pops the whole head group. No request is issued while the buffer is full. A redirect clears the buffer and drops any response in flight.
module fetch_unit #(
    parameter int          SS         = 2,
    parameter int          FBUF_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h6000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_valid,
    input  logic [31:0]       flush_pc,
    input  logic              predict_valid,
    input  logic [31:0]       predict_pc,
    output logic [31:0]       imem_addr,
    output logic              imem_rmask,
    input  logic [32*SS-1:0]  imem_rdata,
    input  logic              imem_resp,
    output logic [SS-1:0]     out_valid,
    output logic [32*SS-1:0]  out_inst,
    output logic [32*SS-1:0]  out_pc,
    input  logic              out_ready
);
    localparam logic [31:0] PC_STEP = 32'(4 * SS);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0]      pc;
        logic [32*SS-1:0] inst;
    } group_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        redirect;
    logic [31:0] redir_raw;
    logic [31:0] redir_pc;
    logic        issue;
    logic        accept;
    logic        pop;
    logic        buf_vld;
    logic        buf_full;
    group_t      push_dat;
    group_t      head_dat;

    // A commit flush outranks a predictor redirect; targets are forced to word alignment
    assign redirect  = flush_valid || predict_valid;
    assign redir_raw = flush_valid ? flush_pc : predict_pc;
    assign redir_pc  = redir_raw & ~32'h3;

    // Nothing is in flight in IDLE, so a free buffer entry is enough to reserve room for the response
    assign issue  = (state_q == IDLE) && !buf_full && !rst;
    assign accept = (state_q == WAIT) && imem_resp && !redirect;
    assign pop    = buf_vld && out_ready && !redirect;

    assign push_dat.pc   = pc_q;
    assign push_dat.inst = imem_rdata;

    fifo #(
        .W     ($bits(group_t)),
        .DEPTH (FBUF_DEPTH)
    ) u_fbuf (
        .clk    (clk),
        .rst    (rst),
        .clr    (redirect),
        .wr_vld (accept),
        .wr_dat (push_dat),
        .rd_rdy (pop),
        .rd_vld (buf_vld),
        .rd_dat (head_dat),
        .full   (buf_full)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and request outputs; a request issued under a redirect is still tracked, so its response is dropped
    always_comb begin
        state_d    = state_q;
        imem_rmask = issue;
        imem_addr  = (state_q == IDLE) ? pc_q : addr_q;
        case (state_q)
            IDLE: begin
                if (issue) state_d = redirect ? DROP : WAIT;
            end
            WAIT: begin
                if (imem_resp)     state_d = IDLE;
                else if (redirect) state_d = DROP;
            end
            DROP: begin
                if (imem_resp) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Fetch PC advances only on an accepted group; a redirect overrides it. addr_q holds the address in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            addr_q <= RESET_PC;
        end else begin
            if (redirect)    pc_q <= redir_pc;
            else if (accept) pc_q <= pc_q + PC_STEP;
            if (issue) addr_q <= pc_q;
        end
    end

    // Head group presentation; slot PCs are derived from the group PC
    always_comb begin
        out_valid = {SS{buf_vld}};
        out_inst  = head_dat.inst;
        out_pc    = '0;
        for (int i = 0; i < SS; i++) begin
            out_pc[32*i +: 32] = head_dat.pc + 32'(4 * i);
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_valid;
    logic [31:0] flush_pc;
    logic        predict_valid;
    logic [31:0] predict_pc;
    logic [31:0] imem_addr;
    logic        imem_rmask;
    logic [63:0] imem_rdata;
    logic        imem_resp;
    logic [1:0]  out_valid;
    logic [63:0] out_inst;
    logic [63:0] out_pc;
    logic        out_ready;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.SS(2), .FBUF_DEPTH(4), .RESET_PC(32'h6000_0000)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_valid   (flush_valid),
        .flush_pc      (flush_pc),
        .predict_valid (predict_valid),
        .predict_pc    (predict_pc),
        .imem_addr     (imem_addr),
        .imem_rmask    (imem_rmask),
        .imem_rdata    (imem_rdata),
        .imem_resp     (imem_resp),
        .out_valid     (out_valid),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .out_ready     (out_ready)
    );

    // Memory model: each instruction word is the bitwise inverse of its address
    function automatic logic [63:0] grp_data(input logic [31:0] a);
        return {~(a + 32'd4), ~a};
    endfunction

    function automatic logic [63:0] grp_pc(input logic [31:0] a);
        return {a + 32'd4, a};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        pv;
        logic [31:0] ppc;
        logic        resp;
        logic [31:0] raddr;
        logic        ordy;
        logic        e_rmask;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        e_oval;
        logic [31:0] e_pc0;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic fv, input logic [31:0] fpc, input logic pv, input logic [31:0] ppc,
                       input logic resp, input logic [31:0] raddr, input logic ordy,
                       input logic e_rmask, input logic chk_addr, input logic [31:0] e_addr,
                       input logic e_oval, input logic [31:0] e_pc0);
        vec_t v;
        v.fv = fv; v.fpc = fpc; v.pv = pv; v.ppc = ppc; v.resp = resp; v.raddr = raddr;
        v.ordy = ordy; v.e_rmask = e_rmask; v.chk_addr = chk_addr; v.e_addr = e_addr;
        v.e_oval = e_oval; v.e_pc0 = e_pc0;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; flush_valid = 1'b0; flush_pc = '0; predict_valid = 1'b0; predict_pc = '0;
        imem_resp = 1'b0; imem_rdata = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic        pending;
        logic [31:0] paddr;
        logic [31:0] exp_req;
        logic [31:0] exp_pop;
        int          reqs;
        int          pops;

        //    fv fpc           pv ppc           resp raddr        ordy rmask chka addr          oval pc0
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_0000, 0, 0);
        add(0, 0,            0, 0,            1, 32'h6000_0000, 1, 0, 1, 32'h6000_0000, 0, 0);
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_0008, 1, 32'h6000_0000);
        add(0, 0,            0, 0,            1, 32'h6000_0008, 1, 0, 1, 32'h6000_0008, 0, 0);
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_0010, 1, 32'h6000_0008);
        add(1, 32'h6000_1003, 0, 0,           0, 0,            1, 0, 1, 32'h6000_0010, 0, 0);
        add(0, 0,            0, 0,            1, 32'h6000_0010, 1, 0, 0, 0,             0, 0);
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_1000, 0, 0);
        add(1, 32'h6000_2000, 1, 32'h6000_3000, 0, 0,          1, 0, 1, 32'h6000_1000, 0, 0);
        add(0, 0,            0, 0,            1, 32'h6000_1000, 1, 0, 0, 0,             0, 0);
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_2000, 0, 0);
        add(0, 0,            0, 0,            1, 32'h6000_2000, 1, 0, 1, 32'h6000_2000, 0, 0);
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_2008, 1, 32'h6000_2000);
        add(0, 0,            1, 32'h6000_4000, 1, 32'h6000_2008, 1, 0, 1, 32'h6000_2008, 0, 0);
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_4000, 0, 0);
        add(0, 0,            0, 0,            1, 32'h6000_4000, 1, 0, 1, 32'h6000_4000, 0, 0);
        add(0, 0,            0, 0,            0, 0,            1, 1, 1, 32'h6000_4008, 1, 32'h6000_4000);

        // Reset state while rst is held
        do_reset();
        #1;
        chk("rst_rmask", {63'b0, imem_rmask}, 64'd0);
        chk("rst_addr",  {32'b0, imem_addr},  {32'b0, 32'h6000_0000});
        chk("rst_oval",  {62'b0, out_valid},  64'd0);

        // Vector table: in-order fetch, flush in WAIT, flush-vs-predict priority, redirect with resp
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst           = 1'b0;
            flush_valid   = vecs[i].fv;
            flush_pc      = vecs[i].fpc;
            predict_valid = vecs[i].pv;
            predict_pc    = vecs[i].ppc;
            imem_resp     = vecs[i].resp;
            imem_rdata    = grp_data(vecs[i].raddr);
            out_ready     = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d_rmask", i), {63'b0, imem_rmask}, {63'b0, vecs[i].e_rmask});
            if (vecs[i].chk_addr)
                chk($sformatf("v%0d_addr", i), {32'b0, imem_addr}, {32'b0, vecs[i].e_addr});
            chk($sformatf("v%0d_oval", i), {62'b0, out_valid}, vecs[i].e_oval ? 64'd3 : 64'd0);
            if (vecs[i].e_oval) begin
                chk($sformatf("v%0d_pc", i),   out_pc,   grp_pc(vecs[i].e_pc0));
                chk($sformatf("v%0d_inst", i), out_inst, grp_data(vecs[i].e_pc0));
            end
        end

        // Buffer fills with out_ready low, then drains in order while issuing resumes
        do_reset();
        out_ready = 1'b0;
        pending = 1'b0; paddr = '0; reqs = 0; pops = 0;
        exp_req = 32'h6000_0000; exp_pop = 32'h6000_0000;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            rst = 1'b0;
            imem_resp  = pending;
            imem_rdata = grp_data(paddr);
            pending    = 1'b0;
            #1;
            if (imem_rmask) begin
                chk($sformatf("fill_req%0d", reqs), {32'b0, imem_addr}, {32'b0, exp_req});
                reqs++; paddr = imem_addr; pending = 1'b1; exp_req += 32'd8;
            end
        end
        chk("fill_reqs", reqs, 64'd4);
        chk("fill_oval", {62'b0, out_valid}, 64'd3);
        chk("fill_head", out_pc, grp_pc(32'h6000_0000));
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready  = 1'b1;
            imem_resp  = pending;
            imem_rdata = grp_data(paddr);
            pending    = 1'b0;
            #1;
            if (out_valid[0]) begin
                chk($sformatf("drain_pc%0d", pops), out_pc, grp_pc(exp_pop));
                pops++; exp_pop += 32'd8;
            end
            if (imem_rmask) begin
                chk($sformatf("drain_req%0d", reqs), {32'b0, imem_addr}, {32'b0, exp_req});
                reqs++; paddr = imem_addr; pending = 1'b1; exp_req += 32'd8;
            end
        end
        chk("drain_pops",   {63'b0, pops >= 8}, 64'd1);
        chk("drain_resume", {63'b0, reqs >= 8}, 64'd1);

        // Reset in WAIT, then a stray response while IDLE
        do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rw_req0", {32'b0, imem_addr}, {32'b0, 32'h6000_0000});
        chk("rw_rmask0", {63'b0, imem_rmask}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rw_rmask_rst", {63'b0, imem_rmask}, 64'd0);
        @(negedge clk);
        rst = 1'b0; imem_resp = 1'b1; imem_rdata = grp_data(32'hBAD0_0000);
        #1;
        chk("rw_rmask1", {63'b0, imem_rmask}, 64'd1);
        chk("rw_addr1",  {32'b0, imem_addr}, {32'b0, 32'h6000_0000});
        chk("rw_oval1",  {62'b0, out_valid}, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            imem_resp = 1'b0;
            #1;
            chk($sformatf("rw_oval_w%0d", c), {62'b0, out_valid}, 64'd0);
            chk($sformatf("rw_rmask_w%0d", c), {63'b0, imem_rmask}, 64'd0);
        end
        @(negedge clk);
        imem_resp = 1'b1; imem_rdata = grp_data(32'h6000_0000);
        @(negedge clk);
        imem_resp = 1'b0;
        #1;
        chk("rw_oval_fin", {62'b0, out_valid}, 64'd3);
        chk("rw_pc_fin",   out_pc,   grp_pc(32'h6000_0000));
        chk("rw_inst_fin", out_inst, grp_data(32'h6000_0000));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
